// File: rtl/wdata_fifo_arb.sv
// -----------------------------------------------------------------------------
// wdata_fifo_arb
// Two-requester write-data arbiter in front of a single data FIFO. A winner is
// chosen by round robin in IDLE. Its burst of len+1 beats then passes
// combinationally to the FIFO port in XFER. One IDLE cycle always separates
// bursts.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req0/req1           burst requests, held until granted
//   len0/len1           burst beats minus one, sampled at grant
//   wvalid0/1, wdata0/1 requester write-data channel
//   wready0/1           requester ready (owner only, mirrors fifo_wready)
//   gnt0/gnt1           registered burst ownership
//   fifo_wvalid/wdata   write channel toward the data FIFO
//   fifo_wready         FIFO can accept (not almost full)
//   busy                registered, high while a burst is in progress
//   burst_done          registered one-cycle pulse after the last beat
// -----------------------------------------------------------------------------
module wdata_fifo_arb #(
   parameter int DATA_WIDTH = 256,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [LEN_WIDTH-1:0]  len0,
   input  logic [LEN_WIDTH-1:0]  len1,
   input  logic                  wvalid0,
   input  logic                  wvalid1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  wready0,
   output logic                  wready1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  fifo_wvalid,
   output logic [DATA_WIDTH-1:0] fifo_wdata,
   input  logic                  fifo_wready,
   output logic                  busy,
   output logic                  burst_done
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   logic [0:0]           state_q, state_d;
   logic                 gnt0_q, gnt0_d;
   logic                 gnt1_q, gnt1_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic                 last_q, last_d;   // 1: requester 1 was served last
   logic                 done_q, done_d;
   logic                 own0_s, own1_s, hs_s, win1_s;

   // Owner data path; gated by rst so nothing is offered while reset is sampled.
   always_comb begin
      own0_s = (state_q == XFER) & gnt0_q & ~rst;
      own1_s = (state_q == XFER) & gnt1_q & ~rst;
      if (own0_s) begin
         fifo_wvalid = wvalid0;
         fifo_wdata  = wdata0;
      end else if (own1_s) begin
         fifo_wvalid = wvalid1;
         fifo_wdata  = wdata1;
      end else begin
         fifo_wvalid = 1'b0;
         fifo_wdata  = '0;
      end
      wready0 = own0_s & fifo_wready;
      wready1 = own1_s & fifo_wready;
      hs_s    = fifo_wvalid & fifo_wready;
   end

   // Arbitration and burst sequencing.
   always_comb begin
      state_d = state_q;
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      done_d  = 1'b0;
      // On a tie the requester not served last wins.
      win1_s  = req1 & (~req0 | ~last_q);
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = XFER;
               gnt0_d  = ~win1_s;
               gnt1_d  = win1_s;
               cnt_d   = win1_s ? len1 : len0;
            end else begin
               state_d = IDLE;
            end
         end
         XFER: begin
            if (hs_s) begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
                  gnt0_d  = 1'b0;
                  gnt1_d  = 1'b0;
                  done_d  = 1'b1;
                  last_d  = gnt1_q;
               end else begin
                  cnt_d = cnt_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
               end
            end else begin
               state_d = XFER;
            end
         end
         default: begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end
      endcase
   end

   // State registers; reset leaves the pointer on requester 1 so 0 wins first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign busy       = (state_q == XFER);
   assign burst_done = done_q;

endmodule
